// File: rtl/pcie_reg_target_if.sv
// rtl/pcie_reg_target_if.sv - Rx stream, register-file and completion signals of pcie_reg_target
interface pcie_reg_target_if #(
   parameter int ADDR_W = 10
);
   logic [63:0]       rx_tdata;
   logic              rx_tvalid;
   logic              rx_tlast;
   logic              rx_tready;

   logic [ADDR_W-1:0] reg_addr;
   logic [31:0]       reg_wr_data;
   logic              reg_wr_valid;
   logic              reg_wr_ack;
   logic              reg_rd;
   logic              reg_rd_ack;
   logic [31:0]       reg_rd_data;

   logic              cpl_req;
   logic              cpl_done;
   logic [31:0]       cpl_data;
   logic [15:0]       cpl_req_id;
   logic [7:0]        cpl_tag;
   logic [2:0]        cpl_tc;
   logic [1:0]        cpl_attr;
   logic [6:0]        cpl_lower_addr;

   // slave: the target engine; master: PCIe core, register file and Tx engine
   modport slave (
      input  rx_tdata, rx_tvalid, rx_tlast,
      output rx_tready,
      output reg_addr, reg_wr_data, reg_wr_valid, reg_rd,
      input  reg_wr_ack, reg_rd_ack, reg_rd_data,
      output cpl_req, cpl_data, cpl_req_id, cpl_tag, cpl_tc, cpl_attr, cpl_lower_addr,
      input  cpl_done
   );

   modport master (
      output rx_tdata, rx_tvalid, rx_tlast,
      input  rx_tready,
      input  reg_addr, reg_wr_data, reg_wr_valid, reg_rd,
      output reg_wr_ack, reg_rd_ack, reg_rd_data,
      input  cpl_req, cpl_data, cpl_req_id, cpl_tag, cpl_tc, cpl_attr, cpl_lower_addr,
      output cpl_done
   );
endinterface

// File: rtl/pcie_reg_target.sv
// rtl/pcie_reg_target.sv - PCIe Rx request engine driving the register-file access interface
module pcie_reg_target #(
   parameter int ADDR_W = 10,
   parameter int ACK_TO = 64,
   parameter int CNT_W  = 16
) (
   input  logic             clk_i,
   input  logic             rst_n,
   pcie_reg_target_if.slave bus,
   output logic [CNT_W-1:0] drop_cnt,
   output logic [CNT_W-1:0] timeout_cnt
);

   localparam int              TO_W    = $clog2(ACK_TO);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TO - 1);

   typedef enum logic [2:0] {
      IDLE, HDR2, WR_WAIT, RD_WAIT, CPL_WAIT, DRAIN
   } state_t;

   state_t state, state_nxt;

   logic [7:0]      hdr_fmt_type;
   logic [9:0]      hdr_length;
   logic [2:0]      hdr_tc;
   logic [1:0]      hdr_attr;
   logic [15:0]     hdr_req_id;
   logic [7:0]      hdr_tag;
   logic [3:0]      hdr_first_be;
   logic [TO_W-1:0] ack_timer;
   logic            ready_en;

   logic beat, is_wr, is_rd, ack_expired;
   logic hdr_load, wr_load, rd_load, drop_inc, to_inc;
   logic unused_bits;

   assign beat        = bus.rx_tvalid && bus.rx_tready;
   assign is_wr       = (hdr_fmt_type == 8'h40) && (hdr_length == 10'd1) && (hdr_first_be == 4'hF);
   assign is_rd       = (hdr_fmt_type == 8'h00) && (hdr_length == 10'd1);
   assign ack_expired = (ack_timer == TO_LAST);

   // ready_en keeps tready low while in reset and for the first cycle after release
   assign bus.rx_tready    = ready_en && ((state == IDLE) || (state == HDR2) || (state == DRAIN));
   assign bus.reg_wr_valid = (state == WR_WAIT);
   assign bus.reg_rd       = (state == RD_WAIT);
   assign bus.cpl_req      = (state == CPL_WAIT);

   // header and address bits without meaning for single-DW register access
   assign unused_bits = ^bus.rx_tdata;

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      hdr_load  = 1'b0;
      wr_load   = 1'b0;
      rd_load   = 1'b0;
      drop_inc  = 1'b0;
      to_inc    = 1'b0;
      unique case (state)
         IDLE: begin
            if (beat) begin
               hdr_load = 1'b1;
               if (bus.rx_tlast) begin
                  drop_inc = 1'b1;
               end else begin
                  state_nxt = HDR2;
               end
            end
         end
         HDR2: begin
            if (beat) begin
               if (is_wr && bus.rx_tlast) begin
                  wr_load   = 1'b1;
                  state_nxt = WR_WAIT;
               end else if (is_rd && bus.rx_tlast) begin
                  rd_load   = 1'b1;
                  state_nxt = RD_WAIT;
               end else begin
                  drop_inc  = 1'b1;
                  state_nxt = bus.rx_tlast ? IDLE : DRAIN;
               end
            end
         end
         DRAIN: begin
            if (beat && bus.rx_tlast) begin
               state_nxt = IDLE;
            end
         end
         WR_WAIT: begin
            if (bus.reg_wr_ack) begin
               state_nxt = IDLE;
            end else if (ack_expired) begin
               to_inc    = 1'b1;
               state_nxt = IDLE;
            end
         end
         RD_WAIT: begin
            // a read always produces a completion, even when abandoned
            if (bus.reg_rd_ack) begin
               state_nxt = CPL_WAIT;
            end else if (ack_expired) begin
               to_inc    = 1'b1;
               state_nxt = CPL_WAIT;
            end
         end
         CPL_WAIT: begin
            if (bus.cpl_done) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         ready_en           <= 1'b0;
         hdr_fmt_type       <= '0;
         hdr_length         <= '0;
         hdr_tc             <= '0;
         hdr_attr           <= '0;
         hdr_req_id         <= '0;
         hdr_tag            <= '0;
         hdr_first_be       <= '0;
         ack_timer          <= '0;
         bus.reg_addr       <= '0;
         bus.reg_wr_data    <= '0;
         bus.cpl_data       <= '0;
         bus.cpl_req_id     <= '0;
         bus.cpl_tag        <= '0;
         bus.cpl_tc         <= '0;
         bus.cpl_attr       <= '0;
         bus.cpl_lower_addr <= '0;
         drop_cnt           <= '0;
         timeout_cnt        <= '0;
      end else begin
         ready_en <= 1'b1;

         if (hdr_load) begin
            hdr_fmt_type <= bus.rx_tdata[31:24];
            hdr_tc       <= bus.rx_tdata[22:20];
            hdr_attr     <= bus.rx_tdata[13:12];
            hdr_length   <= bus.rx_tdata[9:0];
            hdr_req_id   <= bus.rx_tdata[63:48];
            hdr_tag      <= bus.rx_tdata[47:40];
            hdr_first_be <= bus.rx_tdata[35:32];
         end

         if (wr_load || rd_load) begin
            bus.reg_addr <= {bus.rx_tdata[ADDR_W-1:2], 2'b00};
            ack_timer    <= '0;
         end else if ((state == WR_WAIT) || (state == RD_WAIT)) begin
            ack_timer <= ack_timer + 1'b1;
         end

         if (wr_load) begin
            bus.reg_wr_data <= bus.rx_tdata[63:32];
         end

         if (rd_load) begin
            bus.cpl_req_id     <= hdr_req_id;
            bus.cpl_tag        <= hdr_tag;
            bus.cpl_tc         <= hdr_tc;
            bus.cpl_attr       <= hdr_attr;
            bus.cpl_lower_addr <= {bus.rx_tdata[6:2], 2'b00};
         end

         if (state == RD_WAIT) begin
            if (bus.reg_rd_ack) begin
               bus.cpl_data <= bus.reg_rd_data;
            end else if (ack_expired) begin
               bus.cpl_data <= '1;
            end
         end

         if (drop_inc && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
         if (to_inc && (timeout_cnt != '1)) begin
            timeout_cnt <= timeout_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pcie_reg_target.sv
// tb/tb_pcie_reg_target.sv - randomized self-checking bench for pcie_reg_target
module tb_pcie_reg_target;

   localparam int ADDR_W = 10;
   localparam int ACK_TO = 64;
   localparam int CNT_W  = 16;
   localparam int K_DROP = 0;
   localparam int K_WR   = 1;
   localparam int K_RD   = 2;

   logic             clk_i = 1'b0;
   logic             rst_n;
   logic [CNT_W-1:0] drop_cnt;
   logic [CNT_W-1:0] timeout_cnt;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          exp_drop = 0;
   int          exp_to   = 0;
   logic [31:0] regfile [int];

   pcie_reg_target_if #(.ADDR_W(ADDR_W)) bus ();

   pcie_reg_target #(
      .ADDR_W (ADDR_W),
      .ACK_TO (ACK_TO),
      .CNT_W  (CNT_W)
   ) dut (
      .clk_i       (clk_i),
      .rst_n       (rst_n),
      .bus         (bus),
      .drop_cnt    (drop_cnt),
      .timeout_cnt (timeout_cnt)
   );

   always #2 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Only exactly-two-beat, single-DW MWr (all bytes enabled) or MRd is serviced
   function automatic int classify(input logic [7:0] fmt, input logic [9:0] len,
                                   input logic [3:0] be, input int nbeats);
      if (nbeats != 2) return K_DROP;
      if (fmt == 8'h40 && len == 10'd1 && be == 4'hF) return K_WR;
      if (fmt == 8'h00 && len == 10'd1) return K_RD;
      return K_DROP;
   endfunction

   task automatic send_beat(input logic [63:0] d, input logic last);
      int n = 0;
      bus.rx_tdata  = d;
      bus.rx_tvalid = 1'b1;
      bus.rx_tlast  = last;
      while (!bus.rx_tready && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 100) check("rx_tready_wait", 64'(0), 64'(1));
      @(negedge clk_i);
      bus.rx_tvalid = 1'b0;
      bus.rx_tlast  = 1'b0;
   endtask

   task automatic run_tlp(input logic [7:0] fmt, input logic [9:0] len, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [15:0] rid, input logic [7:0] tag,
                          input logic [2:0] tc, input logic [1:0] attr,
                          input int nbeats, input int ack_dly, input int hold);
      logic [31:0]       dw0, dw1, exp_rd;
      logic [ADDR_W-1:0] exp_addr;
      logic [6:0]        exp_low;
      int                kind, n, key;
      dw0      = {fmt, 1'b0, tc, 6'b0, attr, 2'b0, len};
      dw1      = {rid, tag, 4'h0, be};
      exp_addr = {addr[ADDR_W-1:2], 2'b00};
      exp_low  = {addr[6:2], 2'b00};
      key      = int'(addr[ADDR_W-1:2]);
      kind     = classify(fmt, len, be, nbeats);

      send_beat({dw1, dw0}, nbeats == 1);
      for (int b = 1; b < nbeats; b++) begin
         send_beat((b == 1) ? {data, addr} : {$urandom, $urandom}, b == nbeats - 1);
      end

      if (kind == K_DROP) begin
         exp_drop++;
         check("drop_no_wr", 64'(bus.reg_wr_valid), 64'(0));
         check("drop_no_rd", 64'(bus.reg_rd), 64'(0));
         check("drop_tready", 64'(bus.rx_tready), 64'(1));
      end else if (kind == K_WR) begin
         check("wr_valid_latency", 64'(bus.reg_wr_valid), 64'(1));
         check("wr_addr", 64'(bus.reg_addr), 64'(exp_addr));
         check("wr_data", 64'(bus.reg_wr_data), 64'(data));
         check("wr_tready_low", 64'(bus.rx_tready), 64'(0));
         if (ack_dly < 0) begin
            n = 0;
            while (bus.reg_wr_valid && n < ACK_TO + 8) begin
               n++;
               @(negedge clk_i);
            end
            check("wr_timeout_cycles", 64'(n), 64'(ACK_TO));
            exp_to++;
         end else begin
            repeat (ack_dly) @(negedge clk_i);
            check("wr_valid_held", 64'(bus.reg_wr_valid), 64'(1));
            check("wr_tready_held_low", 64'(bus.rx_tready), 64'(0));
            bus.reg_wr_ack = 1'b1;
            @(negedge clk_i);
            bus.reg_wr_ack = 1'b0;
            check("wr_valid_drop", 64'(bus.reg_wr_valid), 64'(0));
            regfile[key] = data;
         end
         check("wr_back_idle", 64'(bus.rx_tready), 64'(1));
      end else begin
         check("rd_req_latency", 64'(bus.reg_rd), 64'(1));
         check("rd_addr", 64'(bus.reg_addr), 64'(exp_addr));
         check("rd_tready_low", 64'(bus.rx_tready), 64'(0));
         exp_rd = regfile.exists(key) ? regfile[key] : {16'hC0DE, 6'b0, exp_addr};
         if (ack_dly < 0) begin
            n = 0;
            while (bus.reg_rd && n < ACK_TO + 8) begin
               n++;
               @(negedge clk_i);
            end
            check("rd_timeout_cycles", 64'(n), 64'(ACK_TO));
            exp_rd = 32'hFFFF_FFFF;
            exp_to++;
         end else begin
            repeat (ack_dly) @(negedge clk_i);
            bus.reg_rd_ack  = 1'b1;
            bus.reg_rd_data = exp_rd;
            @(negedge clk_i);
            bus.reg_rd_ack  = 1'b0;
            bus.reg_rd_data = $urandom;
            check("rd_req_drop", 64'(bus.reg_rd), 64'(0));
         end
         check("cpl_req_latency", 64'(bus.cpl_req), 64'(1));
         check("cpl_data", 64'(bus.cpl_data), 64'(exp_rd));
         check("cpl_req_id", 64'(bus.cpl_req_id), 64'(rid));
         check("cpl_tag", 64'(bus.cpl_tag), 64'(tag));
         check("cpl_tc", 64'(bus.cpl_tc), 64'(tc));
         check("cpl_attr", 64'(bus.cpl_attr), 64'(attr));
         check("cpl_lower_addr", 64'(bus.cpl_lower_addr), 64'(exp_low));
         if (hold >= 0) begin
            repeat (hold) @(negedge clk_i);
            check("cpl_req_held", 64'(bus.cpl_req), 64'(1));
            check("cpl_data_held", 64'(bus.cpl_data), 64'(exp_rd));
            check("cpl_tready_low", 64'(bus.rx_tready), 64'(0));
            bus.cpl_done = 1'b1;
            @(negedge clk_i);
            bus.cpl_done = 1'b0;
            check("cpl_req_drop", 64'(bus.cpl_req), 64'(0));
            check("cpl_back_idle", 64'(bus.rx_tready), 64'(1));
         end
      end
      check("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
      check("timeout_cnt", 64'(timeout_cnt), 64'(exp_to));
   endtask

   initial begin
      logic [7:0]  fmt;
      logic [9:0]  len;
      logic [3:0]  be;
      logic [31:0] addr;
      int          k, nb, dly;

      rst_n           = 1'b0;
      bus.rx_tdata    = '0;
      bus.rx_tvalid   = 1'b0;
      bus.rx_tlast    = 1'b0;
      bus.reg_wr_ack  = 1'b0;
      bus.reg_rd_ack  = 1'b0;
      bus.reg_rd_data = '0;
      bus.cpl_done    = 1'b0;
      repeat (3) @(negedge clk_i);

      check("rst_tready", 64'(bus.rx_tready), 64'(0));
      check("rst_wr_valid", 64'(bus.reg_wr_valid), 64'(0));
      check("rst_rd", 64'(bus.reg_rd), 64'(0));
      check("rst_cpl_req", 64'(bus.cpl_req), 64'(0));
      check("rst_reg_addr", 64'(bus.reg_addr), 64'(0));
      check("rst_cpl_data", 64'(bus.cpl_data), 64'(0));
      check("rst_drop_cnt", 64'(drop_cnt), 64'(0));
      check("rst_timeout_cnt", 64'(timeout_cnt), 64'(0));
      rst_n = 1'b1;
      @(negedge clk_i);

      // directed cases
      run_tlp(8'h40, 10'd1, 4'hF, 32'h0000_0004, 32'hA5A5_1234, 16'h0100, 8'h11, 3'd0, 2'd0, 2, 2, 0);
      regfile[4] = 32'h0000_0030;
      run_tlp(8'h00, 10'd1, 4'hF, 32'h0000_0010, 32'h0, 16'h0100, 8'h2C, 3'd0, 2'd0, 2, 1, 5);
      run_tlp(8'h20, 10'd1, 4'hF, 32'h0000_0040, 32'h0, 16'h0100, 8'h01, 3'd0, 2'd0, 4, 0, 0);
      run_tlp(8'h40, 10'd1, 4'h3, 32'h0000_0008, 32'h1357_9BDF, 16'h0100, 8'h02, 3'd0, 2'd0, 2, 0, 0);
      run_tlp(8'h40, 10'd1, 4'hF, 32'h0000_0008, 32'h2468_ACE0, 16'h0100, 8'h03, 3'd0, 2'd0, 2, 0, 0);
      run_tlp(8'h00, 10'd1, 4'hF, 32'h0000_0020, 32'h0, 16'h0200, 8'h04, 3'd5, 2'd2, 2, -1, 1);

      bus.cpl_done = 1'b1;
      @(negedge clk_i);
      bus.cpl_done = 1'b0;
      check("stray_done_cpl_req", 64'(bus.cpl_req), 64'(0));
      check("stray_done_tready", 64'(bus.rx_tready), 64'(1));

      for (int i = 0; i < 40; i++) begin
         k    = $urandom_range(0, 6);
         addr = $urandom;
         addr[1:0] = 2'b00;
         fmt  = 8'h40;
         len  = 10'd1;
         be   = 4'hF;
         nb   = 2;
         dly  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
         case (k)
            1: begin fmt = 8'h00; be = 4'($urandom); end
            2: begin
               fmt = 8'($urandom);
               if (fmt == 8'h00 || fmt == 8'h40) fmt = 8'h60;
               nb = $urandom_range(2, 4);
            end
            3: be = 4'($urandom_range(0, 14));
            4: nb = 1;
            5: begin fmt = 8'h00; len = 10'($urandom_range(2, 1023)); end
            6: nb = 3;
            default: ;
         endcase
         run_tlp(fmt, len, be, addr, $urandom, 16'($urandom), 8'($urandom), 3'($urandom),
                 2'($urandom), nb, dly, $urandom_range(0, 4));
      end

      // reset while a completion is pending
      run_tlp(8'h00, 10'd1, 4'hF, 32'h0000_0010, 32'h0, 16'h0300, 8'h55, 3'd1, 2'd1, 2, 0, -1);
      rst_n = 1'b0;
      @(negedge clk_i);
      check("rst_cpl_pending_req", 64'(bus.cpl_req), 64'(0));
      check("rst_cpl_pending_tready", 64'(bus.rx_tready), 64'(0));
      check("rst_cpl_pending_drop", 64'(drop_cnt), 64'(0));
      check("rst_cpl_pending_to", 64'(timeout_cnt), 64'(0));
      check("rst_cpl_pending_tag", 64'(bus.cpl_tag), 64'(0));
      check("rst_cpl_pending_data", 64'(bus.cpl_data), 64'(0));
      rst_n    = 1'b1;
      exp_drop = 0;
      exp_to   = 0;
      run_tlp(8'h40, 10'd1, 4'hF, 32'h0000_00FC, 32'hDEAD_BEEF, 16'h0100, 8'h06, 3'd0, 2'd0, 2, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/pcie_reg_target.md
Name: pcie_reg_target

Overview:
- PCIe target-side request engine: the initiator end of the register-file access interface.
- Consumes 64-bit AXI-Stream Rx TLPs from the PCIe core and decodes single-DW MWr32/MRd32.
- Drives register address, write data and write-valid / read-request into the global register file; collects the acks.
- For reads, hands a completion request (header fields plus read data) to the Tx engine and holds it until the Tx engine confirms.

Parameters:
- ADDR_W, 10, register address width presented to the register file.
- ACK_TO, 64, cycles to wait for a register ack before abandoning the access (must be ≥ 2).
- CNT_W, 16, width of the saturating error counters.

Ports:
- clk_i  in  1  250 MHz PCIe user clock.
- rst_n  in  1  synchronous, active-low reset.
- rx_tdata_i  in  64  Rx TLP data; beat0 = {DW1,DW0}, beat1 = {DW3,DW2}.
- rx_tvalid_i  in  1  Rx beat valid.
- rx_tlast_i  in  1  last beat of TLP.
- rx_tready_o  out  1  Rx beat accept.
- reg_addr_o  out  ADDR_W  register address (byte address, bits [1:0] = 0).
- reg_wr_data_o  out  32  register write data.
- reg_wr_valid_o  out  1  write valid, level; held until ack or timeout.
- reg_wr_ack_i  in  1  write ack from register file.
- reg_rd_o  out  1  read request, level; held until ack or timeout.
- reg_rd_ack_i  in  1  read ack; reg_rd_data_i is sampled in the same cycle.
- reg_rd_data_i  in  32  read data.
- cpl_req_o  out  1  completion request to Tx engine.
- cpl_done_i  in  1  Tx engine has sent the completion.
- cpl_data_o  out  32  completion payload.
- cpl_req_id_o  out  16  requester ID.
- cpl_tag_o  out  8  tag.
- cpl_tc_o  out  3  traffic class.
- cpl_attr_o  out  2  attributes.
- cpl_lower_addr_o  out  7  {addr[6:2],2'b00}.
- drop_cnt_o  out  CNT_W  unsupported/malformed TLPs dropped.
- timeout_cnt_o  out  CNT_W  register accesses abandoned by timeout.

Behaviour:
Reset (synchronous, rst_n = 0, takes priority in every state including mid-access):
- State goes to IDLE.
- All outputs 0, including rx_tready_o, both counters and all cpl_* fields.
- Any in-flight access or completion is discarded.

States: IDLE, HDR2, WR_WAIT, RD_WAIT, CPL_WAIT, DRAIN.

IDLE:
- rx_tready_o = 1.
- On tvalid, capture DW0/DW1 into the header registers.
- If tlast = 1 on this beat: drop_cnt++, stay IDLE.
- Otherwise go to HDR2.

HDR2:
- rx_tready_o = 1; on tvalid, decode the header.
- Write: DW0[31:24] = 8'h40, length DW0[9:0] = 1, first BE DW1[3:0] = 4'hF.
  - reg_addr_o = DW2[ADDR_W-1:2], bits [1:0] forced 0.
  - reg_wr_data_o = tdata[63:32].
  - Go to WR_WAIT.
- Read: DW0[31:24] = 8'h00, length = 1, any BE.
  - Latch addr, requester ID DW1[31:16], tag DW1[15:8], TC DW0[22:20], attr DW0[13:12].
  - Go to RD_WAIT.
- Anything else: drop_cnt++.
  - tlast = 1 → IDLE; otherwise → DRAIN.
- A valid-type TLP whose beat1 lacks tlast: drop_cnt++, → DRAIN.

DRAIN:
- rx_tready_o = 1; consume beats until tvalid & tlast, then → IDLE.

WR_WAIT:
- rx_tready_o = 0; reg_wr_valid_o = 1.
- The register file edge-detects valid, so valid rises exactly once per access.
- On reg_wr_ack_i: valid drops the same edge, → IDLE. Minimum one idle cycle with valid low before the next write.
- If ACK_TO cycles elapse without ack: timeout_cnt++, → IDLE.

RD_WAIT:
- rx_tready_o = 0; reg_rd_o = 1.
- On reg_rd_ack_i: capture reg_rd_data_i into cpl_data_o, drop reg_rd_o, → CPL_WAIT.
- On timeout: cpl_data_o = 32'hFFFFFFFF, timeout_cnt++, → CPL_WAIT. A read is always completed.

CPL_WAIT:
- cpl_req_o = 1; all cpl_* fields stable.
- On cpl_done_i: cpl_req_o = 0 the next edge, → IDLE.
- cpl_done_i arriving in any other state is ignored.

Timing and counters:
- Ack-timeout counter resets on entry to WR_WAIT/RD_WAIT.
- Counters saturate at all-ones.
- Latency, MWr beat1 accepted → reg_wr_valid_o high: 1 cycle.
- Latency, MRd beat1 → reg_rd_o: 1 cycle.
- Latency, rd_ack → cpl_req_o: 1 cycle.
- One outstanding request only; back-pressure is by rx_tready_o = 0.

Test Plan:
- MWr32 addr 0x0000_0004, data 0xA5A5_1234, BE F → reg_addr_o = 0x004, reg_wr_data_o = 0xA5A51234, valid high one cycle after beat1, drops after ack, tready low throughout.
- MRd32 addr 0x10, req ID 0x0100, tag 0x2C, register ack returns 0x0000_0030 → cpl_req_o with data 0x30, tag 0x2C, lower_addr 0x10; held 5 cycles until cpl_done_i, then IDLE.
- MRd64 (DW0[31:24] = 8'h20, 4 beats) → all beats drained with tready = 1, drop_cnt = 1, no reg_rd_o.
- MWr32 with BE 4'h3 → dropped, drop_cnt increments, no write issued; a following valid MWr completes normally.
- MRd with reg_rd_ack_i never asserted, ACK_TO = 64 → after 64 cycles timeout_cnt = 1, completion data 0xFFFFFFFF.
- rst_n low during CPL_WAIT → next edge cpl_req_o = 0, tready = 0, counters 0; after release a new MWr is accepted.
